// File: rtl/sha_message_schedule_sequencer.sv
// rtl/sha_message_schedule_sequencer.sv - SHA-256 message schedule sequencer (optional block prefetch via SHA_SCHED_PREFETCH_EN)
module sha_message_schedule_sequencer #(
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    input  logic [15:0][31:0] block_i,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [31:0]       w_o,
    output logic [5:0]        t_o,
    output logic              last_o,
    output logic              busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    state_t            state_q;
    logic [15:0][31:0] win_q;
    logic [5:0]        t_q;

`ifdef SHA_SCHED_PREFETCH_EN
    logic [15:0][31:0] pend_q;
    logic              pend_full_q;
`endif

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    logic [31:0]       w_new;
    logic [15:0][31:0] win_shift_d;
    logic              xfer;
    logic              accept;

    // Next schedule word from the 16-word window; the window slides one word per transfer.
    assign w_new       = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    assign win_shift_d = {w_new, win_q[15:1]};
    assign xfer        = (state_q == RUN) && w_ready_i;
    assign accept      = blk_valid_i && blk_ready_o;

`ifdef SHA_SCHED_PREFETCH_EN
    assign blk_ready_o = !pend_full_q;
`else
    assign blk_ready_o = (state_q == IDLE);
`endif

    // Outputs are pure decodes of registered state, so they hold steady while stalled.
    assign w_valid_o = (state_q == RUN);
    assign busy_o    = (state_q != IDLE);
    assign last_o    = (state_q == RUN) && (t_q == T_LAST);
    assign w_o       = win_q[0];
    assign t_o       = t_q;

    // Sequencer FSM: block load, word streaming, and (optionally) pending-block handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= '0;
            t_q         <= '0;
`ifdef SHA_SCHED_PREFETCH_EN
            pend_q      <= '0;
            pend_full_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        win_q   <= block_i;
                        t_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (xfer && (t_q == T_LAST)) begin
`ifdef SHA_SCHED_PREFETCH_EN
                        // Hand the next block straight to the window so W_0 follows W_last with no bubble.
                        if (pend_full_q) begin
                            win_q       <= pend_q;
                            t_q         <= '0;
                            pend_full_q <= 1'b0;
                        end else if (accept) begin
                            win_q <= block_i;
                            t_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
`else
                        state_q <= IDLE;
`endif
                    end else begin
                        if (xfer) begin
                            win_q <= win_shift_d;
                            t_q   <= t_q + 6'd1;
                        end
`ifdef SHA_SCHED_PREFETCH_EN
                        if (accept) begin
                            pend_q      <= block_i;
                            pend_full_q <= 1'b1;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
